// File: rtl/des_pkg.sv
// Shared widths, wrapper command codes, error codes and FSM state encodings.
package des_pkg;

  localparam int unsigned CMD_W    = 32;
  localparam int unsigned REGION_W = 32;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ERR_W    = 2;

  localparam logic [CMD_W-1:0] CMD_READ_REGION = 32'd0;
  localparam logic [CMD_W-1:0] CMD_START       = 32'd1;
  localparam logic [CMD_W-1:0] CMD_TEST_MODE   = 32'd2;
  localparam logic [CMD_W-1:0] CMD_RESTART     = 32'd3;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_RANGE   = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_START_CMD,
    S_WAIT_DONE,
    S_EMIT,
    S_RESTART_CMD,
    S_NEXT,
    S_TEST_WAIT,
    S_TEST_EMIT,
    S_TEST_ADV,
    S_TEST_GUARD,
    S_FINISH,
    S_ERROR
  } seq_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_RELEASE
  } hs_state_e;

endpackage

// File: rtl/des_cmd_handshake.sv
// Four-phase cmd_valid/cmd_read handshake toward the DES wrapper with a per-phase timeout.
module des_cmd_handshake
  import des_pkg::*;
#(
  parameter int unsigned CMD_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CMD_W-1:0]    cmd_in,
  input  logic [REGION_W-1:0] region_in,
  output logic                busy,
  output logic                ack,
  output logic                timeout,
  output logic [CMD_W-1:0]    cmd,
  output logic [REGION_W-1:0] region,
  output logic                cmd_valid,
  input  logic                cmd_read
);

  localparam int unsigned      TMO_W    = $clog2(CMD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CMD_TIMEOUT - 1);

  hs_state_e           state_q, state_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [REGION_W-1:0] region_q, region_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                tmo_q, tmo_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HS_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      region_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      region_q <= region_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      tmo_q    <= tmo_d;
    end
  end

  // ISSUE waits for cmd_read high, RELEASE for cmd_read low; cmd/region held throughout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    region_d = region_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      HS_IDLE: begin
        if (start) begin
          state_d  = HS_ISSUE;
          cmd_d    = cmd_in;
          region_d = region_in;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      HS_ISSUE: begin
        if (cmd_read) begin
          state_d = HS_RELEASE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = HS_IDLE;
          valid_d  = 1'b0;
          cmd_d    = '0;
          region_d = '0;
          busy_d   = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      HS_RELEASE: begin
        if (!cmd_read) begin
          state_d  = HS_IDLE;
          cmd_d    = '0;
          region_d = '0;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = HS_IDLE;
          cmd_d    = '0;
          region_d = '0;
          busy_d   = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign timeout   = tmo_q;
  assign cmd       = cmd_q;
  assign region    = region_q;
  assign cmd_valid = valid_q;

endmodule

// File: rtl/des_cmd_sequencer.sv
// Host-side sequencer: search sweeps over a region range or test-mode ciphertext collection.
module des_cmd_sequencer
  import des_pkg::*;
#(
  parameter int unsigned CMD_TIMEOUT  = 1024,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                mode,
  input  logic [REGION_W-1:0] region_first,
  input  logic [REGION_W-1:0] region_last,
  input  logic [CNT_W-1:0]    test_count,
  input  logic                abort,
  output logic                busy,
  output logic                err,
  output logic [ERR_W-1:0]    err_code,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [REGION_W-1:0] res_region,
  output logic [DATA_W-1:0]   res_data,
  output logic [DATA_W-1:0]   total_count,
  output logic [CMD_W-1:0]    cmd,
  output logic                cmd_valid,
  output logic [REGION_W-1:0] region,
  output logic                advance_test_cmd,
  input  logic                cmd_read,
  input  logic                done,
  input  logic                test_res_ready,
  input  logic [DATA_W-1:0]   counter,
  input  logic [DATA_W-1:0]   ciphertext
);

  localparam int unsigned      GRD_W    = $clog2(GUARD_CYCLES + 1);
  localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

  seq_state_e          state_q, state_d, ret_q, ret_d;
  logic [CMD_W-1:0]    cmd_sel_q, cmd_sel_d;
  logic                mode_q, mode_d;
  logic [REGION_W-1:0] region_q, region_d, last_q, last_d;
  logic [CNT_W-1:0]    count_q, count_d, sample_q, sample_d;
  logic [GRD_W-1:0]    guard_q, guard_d;
  logic                abort_q, abort_d, busy_q, busy_d, err_q, err_d;
  logic [ERR_W-1:0]    err_code_q, err_code_d;
  logic                res_valid_q, res_valid_d, adv_q, adv_d;
  logic [REGION_W-1:0] res_region_q, res_region_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d, total_q, total_d;
  logic [DATA_W:0]     sum_c;
  logic [CNT_W-1:0]    sample_inc_c;
  logic                hs_start_c, hs_busy, hs_ack, hs_timeout;

  des_cmd_handshake #(.CMD_TIMEOUT(CMD_TIMEOUT)) u_handshake (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (hs_start_c),
    .cmd_in    (cmd_sel_q),
    .region_in (region_q),
    .busy      (hs_busy),
    .ack       (hs_ack),
    .timeout   (hs_timeout),
    .cmd       (cmd),
    .region    (region),
    .cmd_valid (cmd_valid),
    .cmd_read  (cmd_read)
  );

  // State and job registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      cmd_sel_q    <= '0;
      mode_q       <= 1'b0;
      region_q     <= '0;
      last_q       <= '0;
      count_q      <= '0;
      sample_q     <= '0;
      guard_q      <= '0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      res_valid_q  <= 1'b0;
      res_region_q <= '0;
      res_data_q   <= '0;
      total_q      <= '0;
      adv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cmd_sel_q    <= cmd_sel_d;
      mode_q       <= mode_d;
      region_q     <= region_d;
      last_q       <= last_d;
      count_q      <= count_d;
      sample_q     <= sample_d;
      guard_q      <= guard_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      res_valid_q  <= res_valid_d;
      res_region_q <= res_region_d;
      res_data_q   <= res_data_d;
      total_q      <= total_d;
      adv_q        <= adv_d;
    end
  end

  // Job sequencing; every command goes through CMD_ISSUE/CMD_WAIT and returns to ret_q
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    cmd_sel_d    = cmd_sel_q;
    mode_d       = mode_q;
    region_d     = region_q;
    last_d       = last_q;
    count_d      = count_q;
    sample_d     = sample_q;
    guard_d      = guard_q;
    abort_d      = abort_q | (abort && (state_q != S_IDLE) && (state_q != S_ERROR));
    busy_d       = busy_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    res_valid_d  = res_valid_q;
    res_region_d = res_region_q;
    res_data_d   = res_data_q;
    total_d      = total_q;
    adv_d        = adv_q;
    hs_start_c   = 1'b0;
    sum_c        = (DATA_W+1)'(total_q) + (DATA_W+1)'(counter);
    sample_inc_c = sample_q + CNT_W'(1);
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (go) begin
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          abort_d    = 1'b0;
          total_d    = '0;
          mode_d     = mode;
          region_d   = region_first;
          last_d     = region_last;
          count_d    = test_count;
          sample_d   = '0;
          if (region_last < region_first) begin
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
            busy_d     = 1'b0;
            state_d    = S_ERROR;
          end else begin
            busy_d    = 1'b1;
            cmd_sel_d = CMD_READ_REGION;
            ret_d     = S_START_CMD;
            state_d   = S_CMD_ISSUE;
          end
        end
      end
      S_CMD_ISSUE: begin
        if (!hs_busy) begin
          hs_start_c = 1'b1;
          state_d    = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT: begin
        if (hs_timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          busy_d     = 1'b0;
          adv_d      = 1'b0;
          abort_d    = 1'b0;
          state_d    = S_ERROR;
        end else if (hs_ack) begin
          state_d = ret_q;
        end
      end
      S_START_CMD: begin
        cmd_sel_d = mode_q ? CMD_TEST_MODE : CMD_START;
        if (!mode_q)               ret_d = S_WAIT_DONE;
        else if (count_q == '0)    ret_d = S_RESTART_CMD;
        else                       ret_d = S_TEST_WAIT;
        state_d = S_CMD_ISSUE;
      end
      // abort is not honoured here: the wrapper ignores RESTART while running
      S_WAIT_DONE: begin
        if (done) begin
          res_valid_d  = 1'b1;
          res_region_d = region_q;
          res_data_d   = counter;
          total_d      = sum_c[DATA_W] ? '1 : sum_c[DATA_W-1:0];
          state_d      = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_RESTART_CMD;
        end
      end
      S_RESTART_CMD: begin
        cmd_sel_d = CMD_RESTART;
        ret_d     = mode_q ? S_FINISH : S_NEXT;
        state_d   = S_CMD_ISSUE;
      end
      // compare before increment so region_last = all-ones never wraps
      S_NEXT: begin
        if ((region_q == last_q) || abort_q) begin
          state_d = S_FINISH;
        end else begin
          region_d  = region_q + REGION_W'(1);
          cmd_sel_d = CMD_READ_REGION;
          ret_d     = S_START_CMD;
          state_d   = S_CMD_ISSUE;
        end
      end
      S_TEST_WAIT: begin
        if (abort_q) begin
          state_d = S_RESTART_CMD;
        end else if (test_res_ready) begin
          res_valid_d  = 1'b1;
          res_region_d = REGION_W'(sample_q);
          res_data_d   = ciphertext;
          state_d      = S_TEST_EMIT;
        end
      end
      S_TEST_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          adv_d       = 1'b1;
          state_d     = S_TEST_ADV;
        end
      end
      // advance has been high for at least one cycle whenever this state is evaluated
      S_TEST_ADV: begin
        if (!test_res_ready) begin
          adv_d   = 1'b0;
          guard_d = '0;
          state_d = S_TEST_GUARD;
        end
      end
      S_TEST_GUARD: begin
        if (guard_q == GRD_LAST) begin
          sample_d = sample_inc_c;
          state_d  = ((sample_inc_c == count_q) || abort_q) ? S_RESTART_CMD : S_TEST_WAIT;
        end else begin
          guard_d = guard_q + GRD_W'(1);
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy             = busy_q;
  assign err              = err_q;
  assign err_code         = err_code_q;
  assign res_valid        = res_valid_q;
  assign res_region       = res_region_q;
  assign res_data         = res_data_q;
  assign total_count      = total_q;
  assign advance_test_cmd = adv_q;

endmodule

// File: tb/tb_des_cmd_sequencer.sv
// Directed bench for des_cmd_sequencer with a behavioural DES wrapper model.
module tb_des_cmd_sequencer;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go, mode, abort, res_ready;
  logic [31:0] region_first, region_last;
  logic [15:0] test_count;
  logic        busy, err, res_valid, cmd_valid, advance_test_cmd;
  logic [1:0]  err_code;
  logic [31:0] res_region, cmd, region;
  logic [63:0] res_data, total_count;
  logic        cmd_read, done, test_res_ready;
  logic [63:0] counter, ciphertext;

  always #5 clk = ~clk;

  des_cmd_sequencer #(.CMD_TIMEOUT(1024), .GUARD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .region_first(region_first), .region_last(region_last), .test_count(test_count),
    .abort(abort), .busy(busy), .err(err), .err_code(err_code),
    .res_valid(res_valid), .res_ready(res_ready), .res_region(res_region),
    .res_data(res_data), .total_count(total_count), .cmd(cmd), .cmd_valid(cmd_valid),
    .region(region), .advance_test_cmd(advance_test_cmd), .cmd_read(cmd_read),
    .done(done), .test_res_ready(test_res_ready), .counter(counter), .ciphertext(ciphertext)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ct_of(input int i);
    case (i)
      0:       return 64'hA1A1_0000_1111_2222;
      1:       return 64'hB2B2_3333_4444_5555;
      default: return 64'hC3C3_6666_7777_8888;
    endcase
  endfunction

  // Wrapper model knobs and logs
  logic        model_dead = 1'b0;
  int          done_delay = 5;
  logic        throttle = 1'b0;
  logic [63:0] cmd_log [$];
  logic [95:0] res_log [$];
  int          cv_cycles = 0;
  int          adv_pulses = 0;
  logic        adv_prev = 1'b0;
  logic [31:0] cur_region;
  logic        running;
  int          run_cnt, tphase, tidx, tdly;

  // Behavioural wrapper: acks commands one cycle late, raises done / test results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_read <= 1'b0; done <= 1'b0; counter <= '0; test_res_ready <= 1'b0;
      ciphertext <= '0; cur_region <= '0; running <= 1'b0; run_cnt <= 0;
      tphase <= 0; tidx <= 0; tdly <= 0;
    end else begin
      if (!model_dead) cmd_read <= cmd_valid;
      if (running) begin
        if (run_cnt == done_delay) begin
          done <= 1'b1; counter <= 64'(cur_region) * 64'd100; running <= 1'b0;
        end else run_cnt <= run_cnt + 1;
      end
      case (tphase)
        1: if (tdly == 3) begin
             test_res_ready <= 1'b1; ciphertext <= ct_of(tidx); tphase <= 2;
           end else tdly <= tdly + 1;
        2: if (advance_test_cmd) begin test_res_ready <= 1'b0; tphase <= 3; end
        3: if (!advance_test_cmd) begin
             tidx <= tidx + 1; tdly <= 0; tphase <= (tidx + 1 < 3) ? 1 : 0;
           end
        default: ;
      endcase
      if (!model_dead && cmd_valid && !cmd_read) begin
        cmd_log.push_back({cmd, region});
        case (cmd)
          CMD_READ_REGION: cur_region <= region;
          CMD_START:       begin running <= 1'b1; run_cnt <= 0; end
          CMD_TEST_MODE:   begin tphase <= 1; tidx <= 0; tdly <= 0; end
          CMD_RESTART:     begin done <= 1'b0; tphase <= 0; test_res_ready <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  // Result transfers, cmd_valid-high cycles and advance pulses
  always @(posedge clk) begin
    if (rst_n && res_valid && res_ready) res_log.push_back({res_region, res_data});
    if (cmd_valid) cv_cycles++;
    if (advance_test_cmd && !adv_prev) adv_pulses++;
    adv_prev <= advance_test_cmd;
  end

  // Result sink: always ready, or toggling every cycle when throttled
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      res_ready = throttle ? ~res_ready : 1'b1;
    end
  end

  task automatic start_job(input logic m, input logic [31:0] f, input logic [31:0] l,
                           input logic [15:0] tc);
    mode = m; region_first = f; region_last = l; test_count = tc;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  int lb, rb, cb, ab;

  initial begin
    go = 1'b0; mode = 1'b0; abort = 1'b0;
    region_first = '0; region_last = '0; test_count = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", {62'd0, err_code}, 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_total", total_count, 64'd0);
    check("rst_adv", 64'(advance_test_cmd), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Search sweep 5..7
    lb = cmd_log.size(); rb = res_log.size();
    start_job(1'b0, 32'd5, 32'd7, 16'd0);
    check("s1_busy_up", 64'(busy), 64'd1);
    wait_idle(2000, "s1_idle");
    check("s1_nres", 64'(res_log.size() - rb), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (rb + i < res_log.size()) begin
        check("s1_res_region", 64'(res_log[rb+i][95:64]), 64'(5 + i));
        check("s1_res_data", res_log[rb+i][63:0], 64'(500 + 100 * i));
      end
    end
    check("s1_total", total_count, 64'd1800);
    check("s1_ncmd", 64'(cmd_log.size() - lb), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (lb + i < cmd_log.size()) begin
        logic [31:0] ec;
        ec = (i % 3 == 0) ? CMD_READ_REGION : ((i % 3 == 1) ? CMD_START : CMD_RESTART);
        check("s1_cmd", cmd_log[lb+i], {ec, 32'(5 + i / 3)});
      end
    end
    check("s1_err", 64'(err), 64'd0);

    // Single region at the top of the range: no wrap
    lb = cmd_log.size(); rb = res_log.size();
    start_job(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0);
    wait_idle(500, "s2_idle");
    check("s2_nres", 64'(res_log.size() - rb), 64'd1);
    if (rb < res_log.size()) begin
      check("s2_res_region", 64'(res_log[rb][95:64]), 64'h0000_0000_FFFF_FFFF);
      check("s2_res_data", res_log[rb][63:0], 64'd429496729500);
    end
    check("s2_ncmd", 64'(cmd_log.size() - lb), 64'd3);
    repeat (20) @(negedge clk);
    check("s2_no_wrap", 64'(cmd_log.size() - lb), 64'd3);
    check("s2_total", total_count, 64'd429496729500);

    // Bad range
    cb = cv_cycles;
    start_job(1'b0, 32'd10, 32'd9, 16'd0);
    repeat (5) @(negedge clk);
    check("s3_err", 64'(err), 64'd1);
    check("s3_err_code", 64'(err_code), 64'd1);
    check("s3_no_cmd", 64'(cv_cycles - cb), 64'd0);
    check("s3_busy", 64'(busy), 64'd0);

    // cmd_read never rises: timeout
    model_dead = 1'b1;
    cb = cv_cycles;
    start_job(1'b0, 32'd1, 32'd1, 16'd0);
    wait_idle(1200, "s4_idle");
    check("s4_valid_cycles", 64'(cv_cycles - cb), 64'd1024);
    check("s4_err", 64'(err), 64'd1);
    check("s4_err_code", 64'(err_code), 64'd2);
    check("s4_cmd_valid", 64'(cmd_valid), 64'd0);
    model_dead = 1'b0;
    @(negedge clk);

    // Test mode, three samples, throttled result sink
    throttle = 1'b1;
    lb = cmd_log.size(); rb = res_log.size(); ab = adv_pulses;
    start_job(1'b1, 32'h42, 32'h42, 16'd3);
    check("t_err_cleared", 64'(err), 64'd0);
    wait_idle(2000, "t_idle");
    throttle = 1'b0;
    check("t_nres", 64'(res_log.size() - rb), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (rb + i < res_log.size()) begin
        check("t_res_index", 64'(res_log[rb+i][95:64]), 64'(i));
        check("t_res_data", res_log[rb+i][63:0], ct_of(i));
      end
    end
    check("t_adv_pulses", 64'(adv_pulses - ab), 64'd3);
    check("t_ncmd", 64'(cmd_log.size() - lb), 64'd3);
    if (lb + 2 < cmd_log.size()) begin
      check("t_cmd0", cmd_log[lb], {CMD_READ_REGION, 32'h42});
      check("t_cmd1", cmd_log[lb+1], {CMD_TEST_MODE, 32'h42});
      check("t_cmd_last", cmd_log[lb+2], {CMD_RESTART, 32'h42});
    end

    // Abort while region 5 of a 5..9 sweep is running
    done_delay = 20;
    lb = cmd_log.size(); rb = res_log.size();
    start_job(1'b0, 32'd5, 32'd9, 16'd0);
    begin
      int n = 0;
      while (!running && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("a_running", 64'(running), 64'd1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(2000, "a_idle");
    check("a_nres", 64'(res_log.size() - rb), 64'd1);
    if (rb < res_log.size()) check("a_res", res_log[rb], {32'd5, 64'd500});
    check("a_ncmd", 64'(cmd_log.size() - lb), 64'd3);
    if (lb + 2 < cmd_log.size()) check("a_cmd_last", cmd_log[lb+2], {CMD_RESTART, 32'd5});
    check("a_total", total_count, 64'd500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
